// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, well-known scan-code prefixes and receiver states.
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam logic [7:0]  PS2_BREAK      = 8'hF0;
   localparam logic [7:0]  PS2_EXT        = 8'hE0;

   typedef enum logic {
      IDLE,
      SHIFT
   } ps2_rx_state_e;

   // Odd parity over D0..D7 plus the parity bit.
   function automatic logic ps2_parity_ok(input logic [8:0] data_par);
      return ^data_par;
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with a sticky overflow flag.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ps2_byte_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop_req,
   output logic [7:0] rdata,
   output logic       not_empty,
   output logic       overflow
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] Full = (PtrW + 1)'(Depth);

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic [7:0]      mem_q [Depth];
   logic            overflow_q;

   logic full, pop, do_write, drop;

   always_comb begin
      full      = (count_q == Full);
      not_empty = (count_q != '0);
      pop       = not_empty & pop_req;
      do_write  = push & (~full | pop);
      drop      = push & full & ~pop;
      rdata     = mem_q[rd_ptr_q];
      overflow  = overflow_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         if (do_write) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_write && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_write && pop) begin
            count_q <= count_q - 1'b1;
         end
         // Set takes priority over the clear-on-pop.
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (pop) begin
            overflow_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, frame deframer with watchdog,
// and a scan-code FIFO feeding the key-display logic.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] key,
   output logic       key_ready,
   output logic       key_overflow,
   output logic       frame_err
);

   localparam int unsigned WdW     = $clog2(TIMEOUT_CYC);
   localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);
   localparam logic [3:0] LastBit  = 4'(PS2_FRAME_BITS - 1);

   logic [1:0] ps2_clk_sync_q, ps2_data_sync_q;
   logic       ps2_clk_hist_q;
   logic       fe, rx_bit;

   ps2_rx_state_e  state_q, state_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [8:0]     shift_q, shift_d;
   logic [WdW-1:0] wd_q, wd_d;
   logic           err_q, err_d;
   logic           push;
   logic [9:0]     frame_bits;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         ps2_clk_sync_q  <= 2'b11;
         ps2_data_sync_q <= 2'b11;
         ps2_clk_hist_q  <= 1'b1;
      end else begin
         ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
         ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
         ps2_clk_hist_q  <= ps2_clk_sync_q[1];
      end
   end

   assign fe     = ps2_clk_hist_q & ~ps2_clk_sync_q[1];
   assign rx_bit = ps2_data_sync_q[1];

   // Nine stored bits plus the bit arriving now make up the 10-bit frame body
   // {stop, parity, D7..D0} on the final edge.
   assign frame_bits = {rx_bit, shift_q};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wd_d      = wd_q;
      err_d     = 1'b0;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (fe) begin
               if (!rx_bit) begin
                  state_d   = SHIFT;
                  bit_cnt_d = 4'd1;
                  shift_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (fe) begin
               wd_d      = '0;
               shift_d   = frame_bits[9:1];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LastBit) begin
                  state_d = IDLE;
                  if (ps2_parity_ok(frame_bits[8:0]) && frame_bits[9]) begin
                     push = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end else if (wd_q == WdMax) begin
               state_d = IDLE;
               err_d   = 1'b1;
               wd_d    = '0;
               shift_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wd_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
      end
   end

   assign frame_err = err_q;

   ps2_byte_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst       (rst),
      .push      (push),
      .wdata     (frame_bits[7:0]),
      .pop_req   (~nextdata_n),
      .rdata     (key),
      .not_empty (key_ready),
      .overflow  (key_overflow)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins and
// the FIFO outputs are checked against hand-computed values.
module tb_ps2_rx_fifo;

   logic       clk_i = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] key;
   logic       key_ready, key_overflow, frame_err;

   int checks = 0;
   int errors = 0;

   // Monitor state, written only by the monitor processes.
   int         err_cycles = 0;
   int         pop_n = 0;
   logic [7:0] pop_log [64];

   int err_base, pop_base;

   ps2_rx_fifo #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (200)
   ) dut (
      .clk_i        (clk_i),
      .rst          (rst),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .nextdata_n   (nextdata_n),
      .key          (key),
      .key_ready    (key_ready),
      .key_overflow (key_overflow),
      .frame_err    (frame_err)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (frame_err) err_cycles <= err_cycles + 1;
   end

   always @(negedge clk_i) begin
      if (key_ready && !nextdata_n) begin
         pop_log[pop_n[5:0]] <= key;
         pop_n <= pop_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // One PS/2 bit at a 40-cycle period; data settles before the falling edge.
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_clk(10);
      ps2_clk = 1'b0;
      wait_clk(20);
      ps2_clk = 1'b1;
      wait_clk(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      wait_clk(10);
   endtask

   initial begin
      logic [7:0] exp_b;

      // Reset state
      wait_clk(4);
      @(negedge clk_i);
      check("rst_key", 32'(key), 32'h00);
      check("rst_ready", 32'(key_ready), 32'h0);
      check("rst_ovf", 32'(key_overflow), 32'h0);
      check("rst_err", 32'(frame_err), 32'h0);
      wait_clk(1);
      rst = 1'b0;
      wait_clk(5);

      // Single frame, consumer always ready
      err_base = err_cycles;
      pop_base = pop_n;
      nextdata_n = 1'b0;
      send_frame(8'h1C, 1'b0);
      check("single_pops", 32'(pop_n - pop_base), 32'd1);
      check("single_key", 32'(pop_log[pop_base[5:0]]), 32'h1C);
      check("single_err", 32'(err_cycles - err_base), 32'd0);
      check("single_ready_after", 32'(key_ready), 32'h0);
      nextdata_n = 1'b1;

      // Make/break sequence held in the FIFO, then drained back to back
      send_frame(8'h1C, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("mb_ready", 32'(key_ready), 32'h1);
      check("mb_head", 32'(key), 32'h1C);
      @(posedge clk_i); #1;
      nextdata_n = 1'b0;
      @(negedge clk_i);
      check("mb_pop0", 32'({key_ready, key}), 32'h11C);
      @(negedge clk_i);
      check("mb_pop1", 32'({key_ready, key}), 32'h1F0);
      @(negedge clk_i);
      check("mb_pop2", 32'({key_ready, key}), 32'h11C);
      @(negedge clk_i);
      check("mb_empty", 32'(key_ready), 32'h0);
      @(posedge clk_i); #1;
      nextdata_n = 1'b1;

      // Bad parity, then a good frame
      err_base = err_cycles;
      send_frame(8'h1C, 1'b1);
      check("par_err_pulse", 32'(err_cycles - err_base), 32'd1);
      check("par_ready", 32'(key_ready), 32'h0);
      send_frame(8'h32, 1'b0);
      check("par_next_ready", 32'(key_ready), 32'h1);
      check("par_next_key", 32'(key), 32'h32);
      check("par_no_more_err", 32'(err_cycles - err_base), 32'd1);
      @(posedge clk_i); #1;
      nextdata_n = 1'b0;
      @(posedge clk_i); #1;
      nextdata_n = 1'b1;
      check("par_drained", 32'(key_ready), 32'h0);

      // Overflow: nine frames into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
      check("ovf_flag", 32'(key_overflow), 32'h1);
      check("ovf_head", 32'(key), 32'h01);
      @(posedge clk_i); #1;
      nextdata_n = 1'b0;
      @(negedge clk_i);
      check("ovf_pop_key", 32'(key), 32'h01);
      check("ovf_flag_during_pop", 32'(key_overflow), 32'h1);
      @(posedge clk_i); #1;
      nextdata_n = 1'b1;
      @(negedge clk_i);
      check("ovf_cleared", 32'(key_overflow), 32'h0);
      check("ovf_next_head", 32'(key), 32'h02);
      pop_base = pop_n;
      @(posedge clk_i); #1;
      nextdata_n = 1'b0;
      wait_clk(12);
      nextdata_n = 1'b1;
      check("ovf_drain_count", 32'(pop_n - pop_base), 32'd7);
      for (int i = 0; i < 7; i++) begin
         exp_b = 8'(i + 2);
         check("ovf_drain_byte", 32'(pop_log[6'(pop_base + i)]), 32'(exp_b));
      end
      check("ovf_empty", 32'(key_ready), 32'h0);

      // Timeout on a partial frame, then a good frame
      err_base = err_cycles;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      wait_clk(300);
      check("to_err_pulse", 32'(err_cycles - err_base), 32'd1);
      check("to_ready", 32'(key_ready), 32'h0);
      send_frame(8'h45, 1'b0);
      check("to_next_key", 32'({key_ready, key}), 32'h145);
      check("to_no_more_err", 32'(err_cycles - err_base), 32'd1);
      @(posedge clk_i); #1;
      nextdata_n = 1'b0;
      @(posedge clk_i); #1;
      nextdata_n = 1'b1;

      // Reset in the middle of a frame, with a byte still queued
      err_base = err_cycles;
      send_frame(8'h66, 1'b0);
      check("mr_queued", 32'({key_ready, key}), 32'h166);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      rst = 1'b1;
      wait_clk(2);
      @(negedge clk_i);
      check("mr_key", 32'(key), 32'h00);
      check("mr_ready", 32'(key_ready), 32'h0);
      check("mr_ovf", 32'(key_overflow), 32'h0);
      check("mr_err", 32'(frame_err), 32'h0);
      @(posedge clk_i); #1;
      rst = 1'b0;
      ps2_data = 1'b1;
      wait_clk(20);
      send_frame(8'h29, 1'b0);
      check("mr_next_key", 32'({key_ready, key}), 32'h129);
      check("mr_no_err", 32'(err_cycles - err_base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receiver front end. It samples the raw `ps2_clk`/`ps2_data` pins, deframes 11-bit device-to-host frames and checks start, parity and stop bits. Valid scan-code bytes go into a small FIFO. The block sits directly upstream of the key-display FSM and drives its `key`, `key_ready` and `key_overflow` inputs, taking `nextdata_n` back as the pop request.

## Interface
- `FIFO_DEPTH`, default 8: scan-code FIFO entries; must be a power of 2, at least 2.
- `TIMEOUT_CYC`, default 100000: clk_i cycles with no PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- `clk_i`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `nextdata_n`  in  1  active-low pop request; sampled only while `key_ready` = 1.
- `key`  out  8  scan code at the FIFO head; only meaningful while `key_ready` = 1.
- `key_ready`  out  1  FIFO not empty.
- `key_overflow`  out  1  sticky flag: a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_data` each pass through 2 flops, then 1 history flop. A falling edge (`fe`) is when the history flop is 1 and the sync output is 0. Data is sampled from the synchronised `ps2_data` in the same cycle as `fe`.
- **FSM state IDLE:**
  - On `fe` with data = 0 (start bit): go to SHIFT, bit count = 1.
  - On `fe` with data = 1: stay in IDLE and pulse `frame_err`.
- **FSM state SHIFT:**
  - Each `fe` shifts the data bit into a 10-bit register and increments the bit count.
  - Bits 1–8 are D0–D7, LSB first; bit 9 is parity; bit 10 is stop.
  - On the `fe` that receives bit 10:
    - Check that parity is odd, i.e. XOR of D0–D7 and the parity bit = 1, and that stop = 1.
    - On pass: push D7..D0. On fail: pulse `frame_err`, no push.
    - Go to IDLE.
- **Timeout:**
  - A watchdog counter clears on every `fe` and counts while in SHIFT.
  - When it reaches `TIMEOUT_CYC`-1: go to IDLE, pulse `frame_err`, discard partial data.
- **FIFO:**
  - Read/write pointers of log2(`FIFO_DEPTH`) bits plus an occupancy count of log2(`FIFO_DEPTH`)+1 bits; pointers wrap modulo depth.
  - `key` is the entry at the read pointer (combinational read). `key_ready` is count ≠ 0.
  - Pop happens when `key_ready` = 1 and `nextdata_n` = 0; a pop while empty is ignored.
- **Push while full:**
  - With no pop in the same cycle: the byte is dropped and `key_overflow` is set.
  - With a simultaneous pop: both happen and the count is unchanged.
- **Overflow clear:** `key_overflow` clears on the first pop after it was set. If a drop and a pop fall in the same cycle, set wins.
- **Break code:** 0xF0 is stored like any other byte; interpretation belongs downstream.

## Timing
- **Reset:**
  - Outputs: `key` = 0x00 (storage is cleared), `key_ready` = 0, `key_overflow` = 0, `frame_err` = 0.
  - Internal: FSM in IDLE, pointers, count and watchdog = 0, sync flops = 1 (idle bus level).
- **Mid-frame reset:** the partial frame is lost. The next start bit received after reset deframes normally.
- **Edge-detect latency:** a falling edge on the pin produces `fe` 3 clk_i cycles later, with ±1 cycle of synchroniser uncertainty.
- **Push latency:** the push occurs at the clock edge ending the bit-10 `fe` cycle. `key_ready` and the new `key` are visible on the next cycle.
- **Pop latency:** with `nextdata_n` held at 0, each byte is presented for exactly 1 cycle and `key_ready` drops the cycle after the last pop. Back-to-back bytes in the FIFO give consecutive `key_ready` cycles.
- **`frame_err` timing:** the pulse lasts exactly 1 cycle, in the cycle after the offending `fe` or timeout.

## Structure
- Shared package `ps2_pkg`:
  - `PS2_FRAME_BITS` = 11.
  - `PS2_BREAK` = 8'hF0, also used by the display FSM.
  - `PS2_EXT` = 8'hE0.
  - Receiver state enum {IDLE, SHIFT}.
- One sub-module, `ps2_byte_fifo`: parameterised synchronous FIFO with the push/pop/overflow rules above. The deframer stays in the top level.

## Test plan
- **Single valid frame:** send byte 0x1C (odd parity bit 0, stop 1) at a 12.5 kHz PS/2 clock with `nextdata_n` = 0 → `key_ready` high for 1 cycle with `key` = 0x1C; `frame_err` stays 0.
- **Make/break sequence:** send 0x1C, 0xF0, 0x1C with `nextdata_n` held at 1 → count = 3; then pull `nextdata_n` low → `key` shows 0x1C, 0xF0, 0x1C on 3 consecutive cycles, then `key_ready` = 0.
- **Bad parity:** send 0x1C with parity bit 1 → one `frame_err` pulse, `key_ready` stays 0; the following good frame 0x32 is received correctly.
- **Overflow:** with `nextdata_n` = 1, send 9 valid frames, 0x01–0x09, with depth 8 → `key_overflow` = 1 and the FIFO holds 0x01–0x08. One pop → `key` = 0x01, and `key_overflow` reads 0 on the next cycle.
- **Timeout and reset:**
  - Send a start bit plus 4 data bits, then idle for more than `TIMEOUT_CYC` cycles → one `frame_err` pulse; the next full frame 0x45 is received correctly.
  - Assert `rst` in the middle of a frame → all outputs return to their reset values and the next frame is received correctly.
